// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// per-stage control word and configuration limits.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  localparam int MAX_STAGES = 8;

  // Control bits that travel with each operation down the pipe.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sat;
  } stage_ctl_t;

  localparam int STAGE_CTL_W = $bits(stage_ctl_t);

  function automatic logic op_cin(input logic [1:0] op, input logic cin);
    logic c;
    c = cin;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice; also exposes the carry into its top bit
// so the final slice can derive signed overflow.
module addsub_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum      = full[W-1:0];
  assign cout     = full[W];
  assign c_msb_in = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract with carry-in ops, flags and valid/ready backpressure.
// Define ADDSUB_SAT_EN to clamp overflowing ADD/SUB results to the signed range.
module pipe_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int NREG  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST  = STAGES - 1;

  generate
    if ((STAGES < 1) || (STAGES > MAX_STAGES) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be divisible by STAGES and STAGES must be 1..8");
    end
  endgenerate

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  // Intermediate stage registers; the final stage lands in the output registers.
  logic [WIDTH-1:0] a_reg   [NREG];
  logic [WIDTH-1:0] b_reg   [NREG];
  logic [WIDTH-1:0] sum_reg [NREG];
  stage_ctl_t       ctl_reg [NREG];

  logic [WIDTH-1:0] src_a       [STAGES];
  logic [WIDTH-1:0] src_b       [STAGES];
  logic [WIDTH-1:0] src_sum     [STAGES];
  stage_ctl_t       src_ctl     [STAGES];
  logic [CHUNK-1:0] chunk_sum   [STAGES];
  logic [WIDTH-1:0] chunk_place [STAGES];
  logic [WIDTH-1:0] sum_next    [STAGES];
  logic             chunk_cout  [STAGES];
  logic             chunk_msb   [STAGES];

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             out_cout_reg, out_ovf_reg, out_zero_reg, out_neg_reg;

  assign advance  = !out_valid_reg | out_ready;
  assign in_ready = advance;
  assign b_eff    = in_op[0] ? ~in_b : in_b;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        assign src_a[gi]   = in_a;
        assign src_b[gi]   = b_eff;
        assign src_sum[gi] = '0;
        assign src_ctl[gi] = '{valid: in_valid, carry: op_cin(in_op, in_cin), sat: !in_op[1]};
      end else begin : g_src_reg
        assign src_a[gi]   = a_reg[gi-1];
        assign src_b[gi]   = b_reg[gi-1];
        assign src_sum[gi] = sum_reg[gi-1];
        assign src_ctl[gi] = ctl_reg[gi-1];
      end

      addsub_chunk #(.W(CHUNK)) u_chunk (
        .a        (src_a[gi][gi*CHUNK +: CHUNK]),
        .b        (src_b[gi][gi*CHUNK +: CHUNK]),
        .cin      (src_ctl[gi].carry),
        .sum      (chunk_sum[gi]),
        .cout     (chunk_cout[gi]),
        .c_msb_in (chunk_msb[gi])
      );

      // Bits above the current chunk are still zero in src_sum, so OR-ing places the slice.
      assign chunk_place[gi] = WIDTH'(chunk_sum[gi]) << (gi * CHUNK);
      assign sum_next[gi]    = src_sum[gi] | chunk_place[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        a_reg[k]   <= '0;
        b_reg[k]   <= '0;
        sum_reg[k] <= '0;
        ctl_reg[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_reg[k]   <= src_a[k];
        b_reg[k]   <= src_b[k];
        sum_reg[k] <= sum_next[k];
        ctl_reg[k] <= '{valid: src_ctl[k].valid, carry: chunk_cout[k], sat: src_ctl[k].sat};
      end
    end
  end

  logic             final_ovf;
  logic [WIDTH-1:0] result;

  assign final_ovf = chunk_msb[LAST] ^ chunk_cout[LAST];

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Overflow direction follows the sign of A for both ADD and SUB.
  always_comb begin
    result = sum_next[LAST];
    if (src_ctl[LAST].sat && final_ovf)
      result = src_a[LAST][WIDTH-1] ? SMIN : SMAX;
  end
`else
  assign result = sum_next[LAST];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_cout_reg  <= 1'b0;
      out_ovf_reg   <= 1'b0;
      out_zero_reg  <= 1'b0;
      out_neg_reg   <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= src_ctl[LAST].valid;
      out_sum_reg   <= result;
      out_cout_reg  <= chunk_cout[LAST];
      out_ovf_reg   <= final_ovf;
      out_zero_reg  <= (result == '0);
      out_neg_reg   <= result[WIDTH-1];
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_cout  = out_cout_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_zero  = out_zero_reg;
  assign out_neg   = out_neg_reg;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub (WIDTH=32, STAGES=2); expectations
// follow ADDSUB_SAT_EN when the bench is built with it.
module tb_pipe_addsub;

  localparam int W = 32;
  localparam int S = 2;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   in_op;
  logic         in_cin;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf, out_zero, out_neg;

  int tests = 0;
  int fails = 0;

  pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic [W-1:0] e_sum,
                        input logic e_cout, input logic e_ovf, input logic e_zero, input logic e_neg);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("[TB] %s: sum=%h cout=%b ovf=%b zero=%b neg=%b latency=%0d",
             name, out_sum, out_cout, out_ovf, out_zero, out_neg, lat);
    tests++;
    if (lat != S) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, S);
    end
    tests++;
    if (out_sum !== e_sum) begin
      fails++; $display("FAIL %s sum: got %h want %h", name, out_sum, e_sum);
    end
    tests++;
    if ({out_cout, out_ovf, out_zero, out_neg} !== {e_cout, e_ovf, e_zero, e_neg}) begin
      fails++;
      $display("FAIL %s flags cout/ovf/zero/neg: got %b%b%b%b want %b%b%b%b", name,
               out_cout, out_ovf, out_zero, out_neg, e_cout, e_ovf, e_zero, e_neg);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; in_cin = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset: out_valid=%b in_ready=%b sum=%h", out_valid, in_ready, out_sum);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    tests++;
    if ({out_sum, out_cout, out_ovf, out_zero, out_neg} !== '0) begin
      fails++; $display("FAIL reset outputs: got sum=%h flags=%b%b%b%b want all 0",
                        out_sum, out_cout, out_ovf, out_zero, out_neg);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    run_op("add_5_7",      2'b00, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_5_7_cin1", 2'b00, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_10_3",     2'b01, 32'd10, 32'd3, 1'b0, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("sub_equal",    2'b01, 32'd5, 32'd5, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_op("sub_min_minus1", 2'b01, 32'h8000_0000, 32'd1, 1'b0,
           SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, SAT);
    run_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("add_max_plus1", 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0,
           SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0, !SAT);
  endtask

  task automatic test_carry_in();
    run_op("adc_ffffffff_0_c1", 2'b10, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sbc_10_3_c0",       2'b11, 32'd10, 32'd3, 1'b0, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("sbc_min_1_c1",      2'b11, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [8] = '{32'h0000_0001, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_FFFF,
                             32'h0000_00FF, 32'h4000_0000, 32'hAAAA_AAAA, 32'h0001_0000};
    logic [W-1:0] vb [8] = '{32'h0000_0002, 32'h0000_0001, 32'h1111_1111, 32'h0000_0002,
                             32'h0000_0F00, 32'h2000_0000, 32'h1111_1111, 32'h0000_FFFF};
    logic [W-1:0] ve [8] = '{32'h0000_0003, 32'h0001_0000, 32'h2345_6789, 32'h0000_0001,
                             32'h0000_0FFF, 32'h6000_0000, 32'hBBBB_BBBB, 32'h0001_FFFF};
    int tx = 0, rx = 0, cyc = 0;
    logic stalled_prev = 1'b0;
    logic saw_not_ready = 1'b0;
    logic [W-1:0] held = '0;
    @(posedge clk); #1;
    while (rx < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      if (tx < 8) begin
        in_valid = 1'b1; in_op = 2'b00; in_cin = 1'b0; in_a = va[tx]; in_b = vb[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready) saw_not_ready = 1'b1;
      if (stalled_prev) begin
        tests++;
        if (out_sum !== held) begin
          fails++; $display("FAIL b2b hold cycle %0d: got %h want %h", cyc, out_sum, held);
        end
      end
      if (out_valid && out_ready) begin
        $display("[TB] b2b result %0d: sum=%h cycle=%0d", rx, out_sum, cyc);
        tests++;
        if (out_sum !== ve[rx]) begin
          fails++; $display("FAIL b2b result %0d: got %h want %h", rx, out_sum, ve[rx]);
        end
        rx++;
      end
      stalled_prev = out_valid && !out_ready;
      held = out_sum;
      if (in_valid && in_ready) tx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (rx != 8) begin fails++; $display("FAIL b2b count: got %0d want 8", rx); end
    tests++;
    if (!saw_not_ready) begin fails++; $display("FAIL b2b in_ready during stall: got 1 want 0"); end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b extra result: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_cin = 1'b0; in_a = 32'd100; in_b = 32'd1;
    @(posedge clk); #1;
    in_a = 32'd200; in_b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL async pre-reset out_valid: got %b want 1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    $display("[TB] async reset: out_valid=%b sum=%h", out_valid, out_sum);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL async out_valid: got %b want 0", out_valid); end
    tests++;
    if ({out_sum, out_cout, out_ovf, out_zero, out_neg} !== '0) begin
      fails++; $display("FAIL async outputs: got sum=%h want 0", out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset_add", 2'b00, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_carry_in();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
